// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence-detector stage. It frames each word with a
// detector state-reset cycle and flags the final bit so downstream logic knows when to sample.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int LW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic [LW-1:0]    in_len,
    input  logic             in_abort,
    output logic             out_data,
    output logic             out_state_reset,
    output logic             out_last,
    output logic             out_busy,
    output logic [7:0]       out_frame_cnt
);

    // Handshake: a word transfers at a rising edge where in_valid && in_ready are both high;
    // in_ready is high only in IDLE, and in_word/in_len are ignored at all other times.

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [LW-1:0]    cnt;

    logic [LW-1:0]    len_c;
    logic [LW-1:0]    shamt;
    logic [WIDTH-1:0] aligned;
    logic             first_bit;
    logic [WIDTH-1:0] aligned_rest;
    logic             next_bit;
    logic [WIDTH-1:0] sr_rest;

    assign in_ready = (state == IDLE);

    // MSB-first words are left-justified so the first bit always sits at the top of sr.
    always_comb begin
        len_c = in_len;
        if (in_len == '0 || in_len > WIDTH_L)
            len_c = WIDTH_L;
        shamt = WIDTH_L - len_c;
        aligned = MSB_FIRST ? (in_word << shamt) : in_word;
        if (MSB_FIRST) begin
            first_bit    = aligned[WIDTH-1];
            aligned_rest = {aligned[WIDTH-2:0], 1'b0};
            next_bit     = sr[WIDTH-1];
            sr_rest      = {sr[WIDTH-2:0], 1'b0};
        end else begin
            first_bit    = aligned[0];
            aligned_rest = {1'b0, aligned[WIDTH-1:1]};
            next_bit     = sr[0];
            sr_rest      = {1'b0, sr[WIDTH-1:1]};
        end
    end

    // cnt holds the number of bits still to come after the one currently on out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sr              <= '0;
            cnt             <= '0;
            out_data        <= 1'b0;
            out_state_reset <= 1'b1;
            out_last        <= 1'b0;
            out_busy        <= 1'b0;
            out_frame_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state           <= SHIFT;
                        sr              <= aligned_rest;
                        cnt             <= len_c - LW'(1);
                        out_data        <= first_bit;
                        out_last        <= (len_c == LW'(1));
                        out_state_reset <= 1'b0;
                        out_busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (in_abort || out_last) begin
                        state           <= IDLE;
                        sr              <= '0;
                        cnt             <= '0;
                        out_data        <= 1'b0;
                        out_last        <= 1'b0;
                        out_state_reset <= 1'b1;
                        out_busy        <= 1'b0;
                        if (!in_abort)
                            out_frame_cnt <= out_frame_cnt + 8'd1;
                    end else begin
                        sr       <= sr_rest;
                        cnt      <= cnt - LW'(1);
                        out_data <= next_bit;
                        out_last <= (cnt == LW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
